// File: rtl/kbd_text_writer.sv
// Scan-code set 2 decoder driving single-cycle writes into the vga text buffer.
// Define KBD_CLEAR_EN to sweep the whole buffer with blanks after reset release.
module kbd_text_writer #(
   parameter int unsigned COLS = 80,
   parameter int unsigned ROWS = 30,
   parameter logic        ATTR = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] kd,
   input  logic       kv,
   output logic       we,
   output logic [6:0] wx,
   output logic [4:0] wy,
   output logic [8:0] wd
);

   localparam logic [6:0] XMAX = 7'(COLS - 1);
   localparam logic [4:0] YMAX = 5'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE,
      BRK,
      EXT,
      EXT_BRK
`ifdef KBD_CLEAR_EN
      , CLEAR
`endif
   } state_t;

   state_t     state;
   logic [6:0] x;
   logic [4:0] y;
   logic       shift;

   logic [6:0] x_inc;
   logic [4:0] y_inc;
   logic       x_last;
   logic [7:0] ch;
   logic       letter;
   logic       printable;

   always_comb begin
      x_last = (x == XMAX);
      x_inc  = x_last ? '0 : x + 7'd1;
      y_inc  = (y == YMAX) ? '0 : y + 5'd1;
   end

   // Letters decoded first so Shift only affects them; digits and space ignore it.
   always_comb begin
      ch = 8'h00;
      case (kd)
         8'h1C: ch = "a";
         8'h32: ch = "b";
         8'h21: ch = "c";
         8'h23: ch = "d";
         8'h24: ch = "e";
         8'h2B: ch = "f";
         8'h34: ch = "g";
         8'h33: ch = "h";
         8'h43: ch = "i";
         8'h3B: ch = "j";
         8'h42: ch = "k";
         8'h4B: ch = "l";
         8'h3A: ch = "m";
         8'h31: ch = "n";
         8'h44: ch = "o";
         8'h4D: ch = "p";
         8'h15: ch = "q";
         8'h2D: ch = "r";
         8'h1B: ch = "s";
         8'h2C: ch = "t";
         8'h3C: ch = "u";
         8'h2A: ch = "v";
         8'h1D: ch = "w";
         8'h22: ch = "x";
         8'h35: ch = "y";
         8'h1A: ch = "z";
         default: ch = 8'h00;
      endcase
      letter = (ch != 8'h00);
      if (letter && shift) ch = ch - 8'h20;
      case (kd)
         8'h16: ch = "1";
         8'h1E: ch = "2";
         8'h26: ch = "3";
         8'h25: ch = "4";
         8'h2E: ch = "5";
         8'h36: ch = "6";
         8'h3D: ch = "7";
         8'h3E: ch = "8";
         8'h46: ch = "9";
         8'h45: ch = "0";
         8'h29: ch = 8'h20;
         default: ;
      endcase
      printable = (ch != 8'h00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef KBD_CLEAR_EN
         state <= CLEAR;
`else
         state <= IDLE;
`endif
         x     <= '0;
         y     <= '0;
         shift <= 1'b0;
         we    <= 1'b0;
         wx    <= '0;
         wy    <= '0;
         wd    <= '0;
      end else begin
         we <= 1'b0;
         case (state)
`ifdef KBD_CLEAR_EN
            // Sweep reuses the cursor; wrapping past the last cell leaves it at (0,0).
            CLEAR: begin
               we <= 1'b1;
               wx <= x;
               wy <= y;
               wd <= {ATTR, 8'h20};
               x  <= x_inc;
               if (x_last) y <= y_inc;
               if (x_last && y == YMAX) state <= IDLE;
            end
`endif
            IDLE: if (kv) begin
               if (kd == 8'hF0) begin
                  state <= BRK;
               end else if (kd == 8'hE0) begin
                  state <= EXT;
               end else if (kd == 8'h12 || kd == 8'h59) begin
                  shift <= 1'b1;
               end else if (kd == 8'h5A) begin
                  x <= '0;
                  y <= y_inc;
               end else if (kd == 8'h66) begin
                  if (x != '0) begin
                     x  <= x - 7'd1;
                     we <= 1'b1;
                     wx <= x - 7'd1;
                     wy <= y;
                     wd <= {ATTR, 8'h20};
                  end else if (y != '0) begin
                     x  <= XMAX;
                     y  <= y - 5'd1;
                     we <= 1'b1;
                     wx <= XMAX;
                     wy <= y - 5'd1;
                     wd <= {ATTR, 8'h20};
                  end
               end else if (printable) begin
                  we <= 1'b1;
                  wx <= x;
                  wy <= y;
                  wd <= {ATTR, ch};
                  x  <= x_inc;
                  if (x_last) y <= y_inc;
               end
            end
            BRK: if (kv) begin
               state <= IDLE;
               if (kd == 8'h12 || kd == 8'h59) shift <= 1'b0;
            end
            EXT: if (kv) begin
               if (kd == 8'hF0) begin
                  state <= EXT_BRK;
               end else begin
                  state <= IDLE;
                  case (kd)
                     8'h75: if (y != '0)   y <= y - 5'd1;
                     8'h72: if (y != YMAX) y <= y + 5'd1;
                     8'h6B: if (x != '0)   x <= x - 7'd1;
                     8'h74: if (x != XMAX) x <= x + 7'd1;
                     default: ;
                  endcase
               end
            end
            EXT_BRK: if (kv) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kbd_text_writer.sv
// Directed bench for kbd_text_writer: byte streams in, logged text-buffer writes checked.
// Build with KBD_CLEAR_EN defined to also exercise the post-reset clear sweep.
module tb_kbd_text_writer;

   localparam int COLS = 80;
   localparam int ROWS = 30;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] kd = '0;
   logic       kv = 1'b0;
   logic       we;
   logic [6:0] wx;
   logic [4:0] wy;
   logic [8:0] wd;

   int tests = 0;
   int fails = 0;
   bit ok;

   logic [7:0]  seq[$];
   logic [20:0] wlog[$];
   logic [20:0] exp[$];

   kbd_text_writer #(.COLS(COLS), .ROWS(ROWS), .ATTR(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .kd(kd), .kv(kv),
      .we(we), .wx(wx), .wy(wy), .wd(wd)
   );

   always #5 clk = ~clk;

   // All tasks start and end 1 time unit after a rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      kv = 1'b0;
      kd = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
`ifdef KBD_CLEAR_EN
      repeat (COLS * ROWS + 2) @(posedge clk);
      #1;
`endif
   endtask

   // Streams seq back-to-back (one byte per clk), logging every write seen.
   task automatic play();
      wlog.delete();
      foreach (seq[i]) begin
         kd = seq[i];
         kv = 1'b1;
         @(posedge clk);
         #1;
         if (we) wlog.push_back({wx, wy, wd});
      end
      kv = 1'b0;
      kd = '0;
      @(posedge clk);
      #1;
      if (we) wlog.push_back({wx, wy, wd});
      seq.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({we, wx, wy, wd} !== 22'd0) begin
         fails++;
         $display("FAIL reset_outputs: got we=%b wx=%0d wy=%0d wd=%h, expected all zero", we, wx, wy, wd);
      end
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      seq = '{8'h1C};
      play();
      exp = '{{7'd0, 5'd0, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL basic_a: got %0d writes first=%h, expected 1 write %h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
      tests++;
      if ({we, wx, wy, wd} !== {1'b0, 7'd0, 5'd0, 9'h061}) begin
         fails++;
         $display("FAIL basic_hold: got we=%b wx=%0d wy=%0d wd=%h, expected we=0 wx=0 wy=0 wd=061", we, wx, wy, wd);
      end
      seq = '{8'h32};
      play();
      exp = '{{7'd1, 5'd0, 9'h062}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL basic_next: got %0d writes first=%h, expected 1 write %h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
   endtask

   task automatic test_shift();
      do_reset();
      seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
      play();
      exp = '{{7'd0, 5'd0, 9'h041}, {7'd1, 5'd0, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL shift_seq: got %0d writes first=%h, expected 2 writes first=%h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
   endtask

   task automatic test_digits();
      do_reset();
      seq = '{8'h12, 8'h16, 8'h1A, 8'h45, 8'h29, 8'hF0, 8'h12, 8'h1A, 8'h05, 8'hF0, 8'h1A};
      play();
      exp = '{{7'd0, 5'd0, 9'h031}, {7'd1, 5'd0, 9'h05A}, {7'd2, 5'd0, 9'h030},
              {7'd3, 5'd0, 9'h020}, {7'd4, 5'd0, 9'h07A}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL digits_seq: got %0d writes first=%h, expected 5 writes first=%h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < COLS + 1; i++) begin seq.push_back(8'hE0); seq.push_back(8'h74); end
      for (int i = 0; i < ROWS + 1; i++) begin seq.push_back(8'hE0); seq.push_back(8'h72); end
      play();
      tests++;
      if (wlog.size() != 0) begin
         fails++;
         $display("FAIL arrow_clamp_nowrite: got %0d writes, expected 0", wlog.size());
      end
      seq = '{8'h29};
      play();
      exp = '{{7'd79, 5'd29, 9'h020}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL wrap_last_cell: got %0d writes first=%h, expected 1 write %h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
      seq = '{8'h1C, 8'h1C, 8'h5A, 8'h1C};
      play();
      exp = '{{7'd0, 5'd0, 9'h061}, {7'd1, 5'd0, 9'h061}, {7'd0, 5'd1, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL wrap_then_enter: got %0d writes first=%h, expected 3 writes first=%h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
      do_reset();
      for (int i = 0; i < ROWS - 1; i++) begin seq.push_back(8'hE0); seq.push_back(8'h72); end
      seq.push_back(8'h5A);
      seq.push_back(8'h1C);
      play();
      exp = '{{7'd0, 5'd0, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL enter_row_wrap: got %0d writes first=%h, expected 1 write %h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
   endtask

   task automatic test_backspace();
      do_reset();
      for (int i = 0; i < 5; i++) begin seq.push_back(8'hE0); seq.push_back(8'h72); end
      seq.push_back(8'h66);
      seq.push_back(8'h1C);
      play();
      exp = '{{7'd79, 5'd4, 9'h020}, {7'd79, 5'd4, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL bs_row_back: got %0d writes first=%h, expected 2 writes first=%h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
      do_reset();
      seq = '{8'h66};
      play();
      tests++;
      if (wlog.size() != 0) begin
         fails++;
         $display("FAIL bs_origin_nowrite: got %0d writes, expected 0", wlog.size());
      end
      seq = '{8'h1C, 8'h66};
      play();
      exp = '{{7'd0, 5'd0, 9'h061}, {7'd0, 5'd0, 9'h020}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL bs_same_row: got %0d writes first=%h, expected 2 writes first=%h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
   endtask

   task automatic test_arrows();
      do_reset();
      seq = '{8'hE0, 8'h75, 8'hE0, 8'h6B, 8'h1C, 8'h66, 8'hE0, 8'h72, 8'h1C};
      play();
      exp = '{{7'd0, 5'd0, 9'h061}, {7'd0, 5'd0, 9'h020}, {7'd0, 5'd1, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL arrow_up_left_down: got %0d writes first=%h, expected 3 writes first=%h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
      seq = '{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h72, 8'h1C, 8'hE0, 8'h74, 8'h1C};
      play();
      exp = '{{7'd0, 5'd1, 9'h061}, {7'd2, 5'd1, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL arrow_break_right: got %0d writes first=%h, expected 2 writes first=%h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      seq = '{8'h12, 8'h1C};
      play();
      kd = 8'h1C;
      kv = 1'b1;
      @(posedge clk);
      #1;
      kv = 1'b0;
      tests++;
      if (we !== 1'b1) begin
         fails++;
         $display("FAIL mid_write_pulse: got we=%b, expected 1", we);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({we, wx, wy, wd} !== 22'd0) begin
         fails++;
         $display("FAIL mid_reset_clear: got we=%b wx=%0d wy=%0d wd=%h, expected all zero", we, wx, wy, wd);
      end
      @(posedge clk);
      #1;
      do_reset();
      seq = '{8'h1C};
      play();
      exp = '{{7'd0, 5'd0, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL mid_reset_state: got %0d writes first=%h, expected 1 write %h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
   endtask

`ifdef KBD_CLEAR_EN
   task automatic test_clear();
      int cnt;
      int ex;
      int ey;
      int first_i;
      int last_i;
      logic [11:0] last_xy;
      rst_n = 1'b0;
      kv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt = 0; ex = 0; ey = 0; first_i = -1; last_i = -1; last_xy = '0; ok = 1;
      for (int i = 0; i < COLS * ROWS + 100; i++) begin
         @(posedge clk);
         #1;
         if (we) begin
            if ({wx, wy, wd} !== {7'(ex), 5'(ey), 9'h020}) ok = 0;
            if (first_i < 0) first_i = i;
            last_i = i;
            last_xy = {wx, wy};
            cnt++;
            ex++;
            if (ex == COLS) begin ex = 0; ey++; end
         end
         if (i == 100) begin kd = 8'h1C; kv = 1'b1; end
         else if (i == 101) begin kd = 8'h12; end
         else if (i == 102) begin kv = 1'b0; kd = '0; end
      end
      tests++;
      if (cnt != COLS * ROWS) begin
         fails++;
         $display("FAIL clear_count: got %0d writes, expected %0d", cnt, COLS * ROWS);
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL clear_order: got out-of-order or non-blank write, expected raster blanks");
      end
      tests++;
      if (last_i - first_i + 1 != cnt) begin
         fails++;
         $display("FAIL clear_contiguous: got span %0d for %0d writes, expected equal", last_i - first_i + 1, cnt);
      end
      tests++;
      if (last_xy !== {7'd79, 5'd29}) begin
         fails++;
         $display("FAIL clear_last: got (%0d,%0d), expected (79,29)", last_xy[11:5], last_xy[4:0]);
      end
      seq = '{8'h1C};
      play();
      exp = '{{7'd0, 5'd0, 9'h061}};
      tests++;
      ok = (wlog.size() == exp.size());
      if (ok) foreach (exp[i]) if (wlog[i] !== exp[i]) ok = 0;
      if (!ok) begin
         fails++;
         $display("FAIL clear_then_type: got %0d writes first=%h, expected 1 write %h", wlog.size(), (wlog.size() > 0) ? wlog[0] : 21'h0, exp[0]);
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef KBD_CLEAR_EN
      test_clear();
`endif
      test_basic();
      test_shift();
      test_digits();
      test_wrap();
      test_backspace();
      test_arrows();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
